// File: rtl/fan_speed_sequencer.sv
// fan_speed_sequencer: button-stepped fan speed levels with slew-limited PWM duty ramp
module fan_speed_sequencer #(
    parameter int PWM_BITS   = 8,
    parameter int PWM_DIV    = 100,
    parameter int RAMP_TICKS = 1_000_000,
    parameter int RAMP_STEP  = 8,
    parameter int LVL1       = 64,
    parameter int LVL2       = 128,
    parameter int LVL3       = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                btn_speed,
    input  logic                timer_off,
    input  logic                ovr_stop,
    output logic                pwm_out,
    output logic                motor_sw,
    output logic [2:0]          speed_led,
    output logic [PWM_BITS-1:0] duty,
    output logic                ramping
);
    localparam int RW = $clog2(RAMP_TICKS + 1);
    localparam int PW = $clog2(PWM_DIV + 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = ~PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(RAMP_STEP);
    typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DN} state_t;
    state_t              state, state_n;
    logic [1:0]          level, level_n;
    logic [PWM_BITS-1:0] duty_n, tgt, tgt_n, pwm_cnt;
    logic [PWM_BITS:0]   up_gap, dn_gap;
    logic [RW-1:0]       rdiv;
    logic [PW-1:0]       pdiv;
    logic                tick, pstep;

    function automatic logic [PWM_BITS-1:0] target_of(input logic [1:0] l);
        return l == 2'd1 ? PWM_BITS'(LVL1) : l == 2'd2 ? PWM_BITS'(LVL2) :
               l == 2'd3 ? PWM_BITS'(LVL3) : '0;
    endfunction

    // Next level, next duty and next FSM state; the ramp step always uses the current target
    always_comb begin
        tick    = rdiv == RW'(RAMP_TICKS - 1);
        pstep   = pdiv == PW'(PWM_DIV - 1);
        tgt     = target_of(level);
        up_gap  = {1'b0, tgt} - {1'b0, duty};
        dn_gap  = {1'b0, duty} - {1'b0, tgt};
        duty_n  = duty;
        if (tick && state == RAMP_UP)
            duty_n = up_gap <= {1'b0, STEP} ? tgt : duty + STEP;
        if (tick && state == RAMP_DN)
            duty_n = dn_gap <= {1'b0, STEP} ? tgt : duty - STEP;
        level_n = timer_off ? 2'd0 : btn_speed ? level + 2'd1 : level;
        if (ovr_stop) begin
            level_n = 2'd0;
            duty_n  = '0;
        end
        tgt_n   = target_of(level_n);
        state_n = (ovr_stop || (level_n == 2'd0 && duty_n == '0)) ? IDLE :
                  duty_n < tgt_n ? RAMP_UP : duty_n > tgt_n ? RAMP_DN : RUN;
    end

    // FSM state, level and duty registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            level <= 2'd0;
            duty  <= '0;
        end else begin
            state <= state_n;
            level <= level_n;
            duty  <= duty_n;
        end
    end

    // Free-running ramp and PWM dividers plus the PWM period counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdiv    <= '0;
            pdiv    <= '0;
            pwm_cnt <= '0;
        end else begin
            rdiv <= tick ? '0 : rdiv + 1'b1;
            pdiv <= pstep ? '0 : pdiv + 1'b1;
            if (pstep)
                pwm_cnt <= pwm_cnt == CNT_MAX ? '0 : pwm_cnt + 1'b1;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out   <= 1'b0;
            motor_sw  <= 1'b0;
            speed_led <= 3'b000;
            ramping   <= 1'b0;
        end else begin
            pwm_out   <= pwm_cnt < duty;
            motor_sw  <= level_n != 2'd0;
            speed_led <= level_n == 2'd0 ? 3'b000 : 3'b001 << (level_n - 2'd1);
            ramping   <= duty != tgt;
        end
    end
endmodule

// File: tb/tb_fan_speed_sequencer.sv
// tb_fan_speed_sequencer: scoreboard bench against a cycle-level behavioural model
module tb_fan_speed_sequencer;
    localparam int RT = 4;
    localparam int RSTEP = 64;
    localparam int PERIOD = 255;

    typedef struct {
        logic       pwm;
        logic       motor;
        logic [2:0] led;
        logic [7:0] duty;
        logic       ramping;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_speed = 1'b0;
    logic       timer_off = 1'b0;
    logic       ovr_stop = 1'b0;
    logic       pwm_out, motor_sw, ramping;
    logic [2:0] speed_led;
    logic [7:0] duty;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   m_level = 0, m_duty = 0, m_rc = 0, m_pc = 0, m_led = 0;
    bit   m_pwm = 0, m_motor = 0, m_ramp = 0;

    fan_speed_sequencer #(
        .PWM_BITS(8), .PWM_DIV(1), .RAMP_TICKS(RT), .RAMP_STEP(RSTEP),
        .LVL1(64), .LVL2(128), .LVL3(255)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_speed(btn_speed), .timer_off(timer_off),
        .ovr_stop(ovr_stop), .pwm_out(pwm_out), .motor_sw(motor_sw),
        .speed_led(speed_led), .duty(duty), .ramping(ramping)
    );

    always #5 clk = ~clk;

    function automatic int tgt_of(int l);
        return l == 1 ? 64 : l == 2 ? 128 : l == 3 ? 255 : 0;
    endfunction

    function automatic void model_reset();
        m_level = 0; m_duty = 0; m_rc = 0; m_pc = 0; m_led = 0;
        m_pwm = 0; m_motor = 0; m_ramp = 0;
    endfunction

    // One clock edge of the behavioural model
    function automatic void model_step(bit btn, bit toff, bit ovr);
        int t, nl, nd;
        t = tgt_of(m_level);
        nd = m_duty;
        if (m_rc == RT - 1) begin
            if (m_duty < t) nd = (t - m_duty <= RSTEP) ? t : m_duty + RSTEP;
            if (m_duty > t) nd = (m_duty - t <= RSTEP) ? t : m_duty - RSTEP;
        end
        nl = toff ? 0 : btn ? (m_level + 1) % 4 : m_level;
        if (ovr) begin
            nl = 0;
            nd = 0;
        end
        m_pwm   = m_pc < m_duty;
        m_ramp  = m_duty != t;
        m_motor = nl != 0;
        m_led   = nl == 0 ? 0 : 1 << (nl - 1);
        m_level = nl;
        m_duty  = nd;
        m_rc    = (m_rc + 1) % RT;
        m_pc    = (m_pc + 1) % PERIOD;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.pwm = m_pwm; e.motor = m_motor; e.led = 3'(m_led);
        e.duty = 8'(m_duty); e.ramping = m_ramp;
        return e;
    endfunction

    function automatic void check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compare DUT outputs against the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pwm_out", int'(pwm_out), int'(e.pwm));
            check("motor_sw", int'(motor_sw), int'(e.motor));
            check("speed_led", int'(speed_led), int'(e.led));
            check("duty", int'(duty), int'(e.duty));
            check("ramping", int'(ramping), int'(e.ramping));
        end
    end

    task automatic cycle(input bit btn, input bit toff, input bit ovr);
        btn_speed = btn; timer_off = toff; ovr_stop = ovr;
        model_step(btn, toff, ovr);
        @(posedge clk);
        #1;
        q.push_back(snap());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        btn_speed = 0; timer_off = 0; ovr_stop = 0;
        model_reset();
        if (q.size() > 0) begin
            q.delete(q.size() - 1);
            q.push_back(snap());
        end
        repeat (n) begin
            @(posedge clk);
            #1;
            q.push_back(snap());
        end
        reset_n = 1'b1;
    endtask

    initial begin
        int ovr_left;
        do_reset(3);
        cycle(1, 0, 0);
        idle(600);
        repeat (3) begin
            cycle(1, 0, 0);
            idle(19);
        end
        idle(300);
        cycle(1, 0, 0);
        idle(30);
        repeat (2) cycle(1, 0, 0);
        idle(20);
        cycle(1, 1, 0);
        idle(20);
        repeat (3) begin
            cycle(1, 0, 0);
            idle(4);
        end
        idle(30);
        for (int i = 0; i < 10; i++) cycle(i % 2 == 0, 0, 1);
        idle(10);
        repeat (3) cycle(1, 0, 0);
        for (int i = 0; i < 50 && m_duty != 128; i++) cycle(0, 0, 0);
        do_reset(3);
        cycle(1, 0, 0);
        idle(20);
        ovr_left = 0;
        repeat (4000) begin
            if ($urandom_range(0, 999) == 0) do_reset(2);
            if (ovr_left == 0 && $urandom_range(0, 299) == 0) ovr_left = $urandom_range(1, 6);
            cycle($urandom_range(0, 14) == 0, $urandom_range(0, 199) == 0, ovr_left > 0);
            if (ovr_left > 0) ovr_left--;
        end
        idle(5);
        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("scoreboard_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
